// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Control sequencer for the multi-cycle processor. It steps through the
//   phases FETCH, DECODE, EVAL, REGREAD, EXEC/MEM, WB and PCUPD. It waits on the
//   ROM/RAM ready handshakes with a bounded timeout, skips phases by
//   instruction class and condition result, owns the program counter and
//   counts retired instructions.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             level; begins execution when sampled in IDLE
//   rom_ready         instruction word valid (handshake in FETCH)
//   ram_ready         RAM access complete (handshake in MEM)
//   is_alu/is_mem/is_branch/is_halt  decoded class, priority halt>branch>mem>alu
//   cond_pass         condition result, valid from REGREAD onward
//   branch_target     PC loaded by a taken branch
//   en_*              one-hot registered phase enables
//   pc, retired       program counter and retired-instruction count
//   busy, done, error status flags (registered)
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned PC_STEP   = 1,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rom_ready,
    input  logic                 ram_ready,
    input  logic                 is_alu,
    input  logic                 is_mem,
    input  logic                 is_branch,
    input  logic                 is_halt,
    input  logic                 cond_pass,
    input  logic [PC_WIDTH-1:0]  branch_target,
    output logic                 en_fetch,
    output logic                 en_decode,
    output logic                 en_eval,
    output logic                 en_regread,
    output logic                 en_exec,
    output logic                 en_mem,
    output logic                 en_wb,
    output logic                 en_pcupd,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]        TMO_MAX = TW'(TIMEOUT);
    localparam logic [PC_WIDTH-1:0]  PC_INC  = PC_WIDTH'(PC_STEP);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_EVAL    = 4'd3;
    localparam logic [3:0] S_REGREAD = 4'd4;
    localparam logic [3:0] S_EXEC    = 4'd5;
    localparam logic [3:0] S_MEM     = 4'd6;
    localparam logic [3:0] S_WB      = 4'd7;
    localparam logic [3:0] S_PCUPD   = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;
    localparam logic [3:0] S_ERROR   = 4'd10;

    logic [3:0]           r_state;
    logic [3:0]           w_next_state;
    logic [TW-1:0]        r_tmo;
    logic [TW-1:0]        w_tmo_next;
    logic                 w_tmo_hit;
    logic [7:0]           r_en;
    logic [7:0]           w_en_next;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [CNT_WIDTH-1:0] r_retired;

    assign w_tmo_hit = (r_tmo == TMO_MAX);

    // Next-state logic; a ready seen on the last allowed cycle wins over the timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_FETCH; else w_next_state = S_IDLE;
            S_FETCH: begin
                if (rom_ready)      w_next_state = S_DECODE;
                else if (w_tmo_hit) w_next_state = S_ERROR;
                else                w_next_state = S_FETCH;
            end
            S_DECODE:  if (is_halt) w_next_state = S_DONE; else w_next_state = S_EVAL;
            S_EVAL:    w_next_state = S_REGREAD;
            S_REGREAD: begin
                // A failed condition squashes the instruction straight to PCUPD.
                if (!cond_pass)     w_next_state = S_PCUPD;
                else if (is_branch) w_next_state = S_PCUPD;
                else if (is_mem)    w_next_state = S_MEM;
                else if (is_alu)    w_next_state = S_EXEC;
                else                w_next_state = S_PCUPD;
            end
            S_EXEC:    w_next_state = S_WB;
            S_MEM: begin
                if (ram_ready)      w_next_state = S_WB;
                else if (w_tmo_hit) w_next_state = S_ERROR;
                else                w_next_state = S_MEM;
            end
            S_WB:      w_next_state = S_PCUPD;
            S_PCUPD:   w_next_state = S_FETCH;
            S_DONE:    if (start) w_next_state = S_DONE; else w_next_state = S_IDLE;
            S_ERROR:   w_next_state = S_ERROR;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Handshake wait counter: restarts on every state entry, counts while waiting.
    always_comb begin
        w_tmo_next = '0;
        if (w_next_state != r_state) begin
            w_tmo_next = '0;
        end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
            w_tmo_next = r_tmo + TW'(1);
        end else begin
            w_tmo_next = '0;
        end
    end

    // Enable decode of the upcoming state so the registered enables line up with it.
    always_comb begin
        w_en_next = 8'h00;
        case (w_next_state)
            S_FETCH:   w_en_next = 8'h01;
            S_DECODE:  w_en_next = 8'h02;
            S_EVAL:    w_en_next = 8'h04;
            S_REGREAD: w_en_next = 8'h08;
            S_EXEC:    w_en_next = 8'h10;
            S_MEM:     w_en_next = 8'h20;
            S_WB:      w_en_next = 8'h40;
            S_PCUPD:   w_en_next = 8'h80;
            default:   w_en_next = 8'h00;
        endcase
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
            r_en    <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_tmo   <= w_tmo_next;
            r_en    <= w_en_next;
            r_busy  <= (w_en_next != 8'h00);
            r_done  <= (w_next_state == S_DONE);
            r_error <= (w_next_state == S_ERROR);
        end
    end

    // Program counter and retired count advance only while leaving PCUPD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_retired <= '0;
        end else if (r_state == S_PCUPD) begin
            if (is_branch && cond_pass) begin
                r_pc <= branch_target;
            end else begin
                r_pc <= r_pc + PC_INC;
            end
            r_retired <= r_retired + CNT_ONE;
        end else begin
            r_pc      <= r_pc;
            r_retired <= r_retired;
        end
    end

    assign en_fetch   = r_en[0];
    assign en_decode  = r_en[1];
    assign en_eval    = r_en[2];
    assign en_regread = r_en[3];
    assign en_exec    = r_en[4];
    assign en_mem     = r_en[5];
    assign en_wb      = r_en[6];
    assign en_pcupd   = r_en[7];
    assign pc         = r_pc;
    assign retired    = r_retired;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for multicycle_sequencer. A 32-bit instance and a narrow
// instance (PC_WIDTH=4, CNT_WIDTH=2) run in lockstep so PC and retired-count
// wrap-around show up on the narrow one. Each directed instruction pushes its
// expected phase-cycle counts, PC and retired count; the monitor pops and
// compares when PCUPD completes, DONE rises or ERROR rises.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst, start, rom_ready, ram_ready;
    logic        is_alu, is_mem, is_branch, is_halt, cond_pass;
    logic [31:0] branch_target;

    logic        en_fetch, en_decode, en_eval, en_regread, en_exec, en_mem, en_wb, en_pcupd;
    logic [31:0] pc;
    logic [15:0] retired;
    logic        busy, done, error;

    logic        s_fetch, s_decode, s_eval, s_regread, s_exec, s_mem, s_wb, s_pcupd;
    logic [3:0]  s_pc;
    logic [1:0]  s_retired;
    logic        s_busy, s_done, s_error;

    always #5 clk = ~clk;

    multicycle_sequencer #(.PC_WIDTH(32), .PC_STEP(1), .TIMEOUT(TMO), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_ready(rom_ready), .ram_ready(ram_ready),
        .is_alu(is_alu), .is_mem(is_mem), .is_branch(is_branch), .is_halt(is_halt),
        .cond_pass(cond_pass), .branch_target(branch_target),
        .en_fetch(en_fetch), .en_decode(en_decode), .en_eval(en_eval), .en_regread(en_regread),
        .en_exec(en_exec), .en_mem(en_mem), .en_wb(en_wb), .en_pcupd(en_pcupd),
        .pc(pc), .retired(retired), .busy(busy), .done(done), .error(error));

    multicycle_sequencer #(.PC_WIDTH(4), .PC_STEP(1), .TIMEOUT(TMO), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .rom_ready(rom_ready), .ram_ready(ram_ready),
        .is_alu(is_alu), .is_mem(is_mem), .is_branch(is_branch), .is_halt(is_halt),
        .cond_pass(cond_pass), .branch_target(branch_target[3:0]),
        .en_fetch(s_fetch), .en_decode(s_decode), .en_eval(s_eval), .en_regread(s_regread),
        .en_exec(s_exec), .en_mem(s_mem), .en_wb(s_wb), .en_pcupd(s_pcupd),
        .pc(s_pc), .retired(s_retired), .busy(s_busy), .done(s_done), .error(s_error));

    // kind: 0 = retired instruction, 1 = done, 2 = error
    typedef struct packed {
        logic [1:0]      kind;
        logic [7:0][7:0] n;     // expected cycles per phase f,d,e,r,x,m,w,p
        logic [31:0]     pc;
        logic [15:0]     ret;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          cnt [8];
    logic [31:0] m_pc;
    logic [15:0] m_ret;
    string       pn [8] = '{"fetch", "decode", "eval", "regread", "exec", "mem", "wb", "pcupd"};

    wire [7:0] w_en = {en_pcupd, en_wb, en_mem, en_exec, en_regread, en_eval, en_decode, en_fetch};
    wire [7:0] w_sen = {s_pcupd, s_wb, s_mem, s_exec, s_regread, s_eval, s_decode, s_fetch};

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic sig(input int s);
        if (s < 8)  return w_en[s];
        if (s == 8) return done;
        return error;
    endfunction

    task automatic wait_sig(input int s);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(s) && n < 200);
        chk($sformatf("wait_sig%0d", s), longint'(sig(s)), 1);
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_big"}, longint'({w_en, busy, done, error, pc, retired}), 0);
        chk({nm, "_small"}, longint'({w_sen, s_busy, s_done, s_error, s_pc, s_retired}), 0);
    endtask

    task automatic check_item(input exp_t e, input logic [1:0] kind);
        chk("sb_kind", longint'(e.kind), longint'(kind));
        chk("pc", longint'(pc), longint'(e.pc));
        chk("retired", longint'(retired), longint'(e.ret));
        chk("pc_narrow", longint'(s_pc), longint'(e.pc[3:0]));
        chk("retired_narrow", longint'(s_retired), longint'(e.ret[1:0]));
        for (int i = 0; i < 8; i++)
            chk($sformatf("cycles_%s", pn[i]), longint'(cnt[i]), longint'(e.n[i]));
    endtask

    // Monitor: per-cycle enable/busy sanity plus scoreboard pops on completion events.
    initial begin : monitor
        bit   pend = 1'b0;
        bit   prev_f = 1'b0;
        bit   done_seen = 1'b0;
        bit   err_seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0; prev_f = 1'b0; done_seen = 1'b0; err_seen = 1'b0;
                continue;
            end
            chk("onehot", longint'($countones(w_en) <= 1), 1);
            chk("busy", longint'(busy), longint'(|w_en));
            if (pend) begin
                pend = 1'b0;
                chk("sb_nonempty", longint'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin e = sb_q.pop_front(); check_item(e, 2'd0); end
            end
            if (w_en[0] && !prev_f) for (int i = 0; i < 8; i++) cnt[i] = 0;
            prev_f = w_en[0];
            for (int i = 0; i < 8; i++) if (w_en[i]) cnt[i]++;
            if (w_en[7]) pend = 1'b1;
            if (done && !done_seen) begin
                chk("sb_nonempty", longint'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin e = sb_q.pop_front(); check_item(e, 2'd1); end
                chk("done_narrow", longint'(s_done), 1);
            end
            done_seen = done;
            if (error && !err_seen) begin
                chk("sb_nonempty", longint'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin e = sb_q.pop_front(); check_item(e, 2'd2); end
                chk("error_narrow", longint'(s_error), 1);
            end
            err_seen = error;
        end
    end

    // One directed instruction: rd = ROM wait cycles, md = RAM wait cycles.
    task automatic run_instr(input int rd, input bit a, input bit m, input bit b, input bit h,
                             input bit c, input logic [31:0] tgt, input int md);
        exp_t e;
        bit   mem_path = 1'b0;
        e = '0;
        e.n[0] = 8'(rd + 1);
        e.n[1] = 8'd1;
        if (h) begin
            e.kind = 2'd1;
        end else begin
            e.kind = 2'd0;
            e.n[2] = 8'd1; e.n[3] = 8'd1; e.n[7] = 8'd1;
            if (c && !b && m) begin
                mem_path = 1'b1; e.n[5] = 8'(md + 1); e.n[6] = 8'd1;
            end else if (c && !b && a) begin
                e.n[4] = 8'd1; e.n[6] = 8'd1;
            end
            m_pc  = (b && c) ? tgt : m_pc + 32'd1;
            m_ret = m_ret + 16'd1;
        end
        e.pc  = m_pc;
        e.ret = m_ret;
        sb_q.push_back(e);
        wait_sig(0);
        is_alu = a; is_mem = m; is_branch = b; is_halt = h; cond_pass = c;
        branch_target = tgt; ram_ready = 1'b0; rom_ready = (rd == 0);
        repeat (rd) @(negedge clk);
        rom_ready = 1'b1;
        if (h) begin
            wait_sig(8);
        end else begin
            if (mem_path) begin
                wait_sig(5);
                repeat (md) @(negedge clk);
                ram_ready = 1'b1;
            end
            wait_sig(7);
        end
    endtask

    task automatic rearm();
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_pc_kept", longint'(pc), longint'(m_pc));
        chk("idle_ret_kept", longint'(retired), longint'(m_ret));
        chk("idle_flags", longint'({busy, done, error}), 0);
        start = 1'b1;
    endtask

    initial begin : stim
        exp_t e;
        rst = 1'b1; start = 1'b0; rom_ready = 1'b0; ram_ready = 1'b0;
        is_alu = 1'b0; is_mem = 1'b0; is_branch = 1'b0; is_halt = 1'b0;
        cond_pass = 1'b0; branch_target = 32'd0;
        m_pc = 32'd0; m_ret = 16'd0;
        repeat (2) @(negedge clk);
        chk_outs_zero("reset");
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk_outs_zero("idle");
        end

        // ALU stream then halt
        start = 1'b1;
        repeat (3) run_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 0);
        run_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 0);
        rearm();

        run_instr(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 4);          // mem, 4 RAM waits
        run_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 0);         // branch taken
        run_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h99, 0);         // branch not taken
        run_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);          // squashed ALU
        run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 0);          // no class
        run_instr(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 0);          // mem beats alu
        run_instr(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4F, 0);         // branch beats mem
        run_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 0);          // narrow pc wraps
        run_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
        run_instr(TMO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 0);        // ready on last ROM cycle, pc wraps
        run_instr(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, TMO);        // ready on last RAM cycle
        run_instr(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 0);          // halt beats alu
        rearm();

        // ROM never ready -> sticky error
        e = '0;
        e.kind = 2'd2; e.n[0] = 8'(TMO + 1); e.pc = m_pc; e.ret = m_ret;
        sb_q.push_back(e);
        wait_sig(0);
        rom_ready = 1'b0; is_halt = 1'b0; is_alu = 1'b1;
        wait_sig(9);
        rom_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("err_sticky", longint'({error, busy, done}), 4);
            chk("err_pc", longint'(pc), longint'(m_pc));
        end

        // Reset out of ERROR, then asynchronous reset in the middle of EXEC
        rst = 1'b1;
        #1 chk_outs_zero("rst_error");
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'd0; m_ret = 16'd0;
        wait_sig(0);
        rom_ready = 1'b1; is_alu = 1'b1; cond_pass = 1'b1;
        wait_sig(4);
        #2 rst = 1'b1;
        #1 chk_outs_zero("rst_exec");
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs_zero("after_rst");
        chk("sb_drained", longint'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Parametrised control sequencer for the multi-cycle processor. It drives the phase enables (fetch, decode, evaluate, register read, execute, memory, writeback, PC update) and owns the program counter. Unlike the fixed-timing scheduler, it waits on ROM/RAM ready handshakes with a timeout, skips phases according to instruction class and condition result, and counts retired instructions. It sits between the instruction decoder/condition evaluator and the register file, ALU, ROM and RAM.

Parameters:
PC_WIDTH, 32, width of pc and branch_target
PC_STEP, 1, pc increment per sequential instruction
TIMEOUT, 15, max cycles waiting for a ready before error; counter width is clog2(TIMEOUT+1)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level; sampled in IDLE to begin execution
rom_ready  in  1  instruction word valid on ROM output
ram_ready  in  1  RAM access complete
is_alu  in  1  decoded class: ALU op (valid from DECODE onward)
is_mem  in  1  decoded class: load/store
is_branch  in  1  decoded class: BX branch
is_halt  in  1  decoded class: halt/done
cond_pass  in  1  condition evaluator result, valid the cycle after EVAL
branch_target  in  PC_WIDTH  target PC (register A contents)
en_fetch, en_decode, en_eval, en_regread, en_exec, en_mem, en_wb, en_pcupd  out  1 each  one-hot phase enables
pc  out  PC_WIDTH  program counter
retired  out  CNT_WIDTH  count of completed instructions
busy  out  1  high in every state except IDLE, DONE and ERROR
done  out  1  high in DONE
error  out  1  high in ERROR (handshake timeout)

Behaviour:
- Reset: state=IDLE; pc=0; retired=0; all enables, busy, done and error = 0; timeout counter=0. Reset asserted mid-operation aborts immediately with no partial PC update.
- Exactly one en_* is high in each phase state; all en_* are low in IDLE/DONE/ERROR. Enables are registered (decoded from the state register, no combinational path from inputs).
- FSM (one transition per clk):
  IDLE: start=1 -> FETCH.
  FETCH (en_fetch): rom_ready=1 -> DECODE; otherwise stay and increment the timeout counter; counter==TIMEOUT -> ERROR.
  DECODE (en_decode): is_halt -> DONE; else -> EVAL.
  EVAL (en_eval): -> REGREAD.
  REGREAD (en_regread): cond_pass=0 -> PCUPD (instruction squashed, no exec/mem/wb); is_branch -> PCUPD; is_mem -> MEM; is_alu -> EXEC; no class set -> PCUPD.
  EXEC (en_exec): -> WB.
  MEM (en_mem): ram_ready=1 -> WB; timeout handled as in FETCH.
  WB (en_wb): -> PCUPD.
  PCUPD (en_pcupd): pc <= (is_branch & cond_pass) ? branch_target : pc+PC_STEP (mod 2^PC_WIDTH, wraps silently); retired <= retired+1 (wraps); -> FETCH.
  DONE: holds pc and retired; start=0 -> IDLE (start must be released before re-arming). Re-entry from IDLE keeps pc and retired; only rst clears them.
  ERROR: sticky until rst; pc frozen at the faulting instruction.
- The timeout counter clears on every state entry; a ready arriving in the same cycle the counter reaches TIMEOUT counts as success (ready takes priority).
- A squashed instruction still increments retired.
- Latency: ALU instruction with ready in the first cycle = 7 cycles (FETCH..PCUPD); memory instruction = 7 + RAM wait cycles; squashed or branch = 5 cycles.
- Class inputs are treated as one-hot; priority if several are set: is_halt > is_branch > is_mem > is_alu.

Test Plan:
- Reset/idle: rst pulse, start=0 -> all outputs 0, state IDLE for 10 cycles; rst asserted asynchronously mid-EXEC -> outputs 0 before the next edge.
- ALU stream: start=1, rom_ready=1 always, 3 ALU instrs with cond_pass=1, then halt -> enables step F,D,E,R,X,W,P per instr; pc=3, retired=3, done=1.
- Memory wait: is_mem with ram_ready asserted 4 cycles after MEM entry -> en_mem held for 5 cycles, then WB; retired increments once.
- Branch taken/not taken: branch_target=0x40, cond_pass=1 -> pc=0x40; same with cond_pass=0 -> pc=old+1 and en_exec/en_wb never assert.
- Timeout: rom_ready=0 held -> error=1 exactly TIMEOUT+1 cycles after FETCH entry, busy=0, pc unchanged; ready arriving on the TIMEOUT cycle -> no error.
- Wrap: PC_WIDTH=4, pc=15, sequential instr -> pc=0; retired at max value -> wraps to 0.
